// File: rtl/l2_mem_pkg.sv
// Shared types and constants for the L2-to-memory beat bridge.
package l2_mem_pkg;

   localparam int unsigned BEAT_WIDTH = 64;
   localparam int unsigned BEAT_BYTES = 8;
   localparam int unsigned BEAT_SHIFT = 3;

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      WR_ISSUE,
      RD_DONE,
      WR_DONE
   } l2mb_state_t;

   // Posted write beat payload latched from the L2 port.
   typedef struct packed {
      logic [BEAT_WIDTH-1:0] wdata;
      logic [BEAT_BYTES-1:0] wstrb;
   } l2mb_wbeat_t;

endpackage

// File: rtl/l2_beat_assembler.sv
// Collects in-order 64-bit read response beats into a full line register.
module l2_beat_assembler
   import l2_mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 256
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clr,
   input  logic                  i_wr,
   input  logic [BEAT_WIDTH-1:0] i_beat,
   output logic [DATA_WIDTH-1:0] o_line,
   output logic                  o_last_c
);

   localparam int unsigned BEATS = DATA_WIDTH / BEAT_WIDTH;
   localparam int unsigned CNT_W = $clog2(BEATS + 1);

   logic [CNT_W-1:0]      rsp_cnt_q, rsp_cnt_d;
   logic [DATA_WIDTH-1:0] line_q,    line_d;

   // Beat k lands in slice k; clear wins over a same-cycle write.
   always_comb begin
      rsp_cnt_d = rsp_cnt_q;
      line_d    = line_q;
      if (i_clr) begin
         rsp_cnt_d = '0;
         line_d    = '0;
      end else if (i_wr) begin
         rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
         for (int unsigned b = 0; b < BEATS; b++) begin
            if (rsp_cnt_q == CNT_W'(b)) begin
               line_d[b*BEAT_WIDTH +: BEAT_WIDTH] = i_beat;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rsp_cnt_q <= '0;
         line_q    <= '0;
      end else begin
         rsp_cnt_q <= rsp_cnt_d;
         line_q    <= line_d;
      end
   end

   assign o_line   = line_q;
   assign o_last_c = (rsp_cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/l2_mem_bridge.sv
// Converts the L2 line-level memory port into a 64-bit beat command/response bus.
module l2_mem_bridge
   import l2_mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 256,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_rreq,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_wvalid,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [BEAT_WIDTH-1:0] i_wdata,
   input  logic [BEAT_BYTES-1:0] i_wstrb,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_rdone,
   output logic                  o_wdone,
   output logic                  o_err,
   output logic                  o_bus_req,
   output logic                  o_bus_we,
   output logic [ADDR_WIDTH-1:0] o_bus_addr,
   output logic [BEAT_WIDTH-1:0] o_bus_wdata,
   output logic [BEAT_BYTES-1:0] o_bus_wstrb,
   input  logic                  i_bus_gnt,
   input  logic                  i_bus_rvalid,
   input  logic [BEAT_WIDTH-1:0] i_bus_rdata
);

   localparam int unsigned BEATS = DATA_WIDTH / BEAT_WIDTH;
   localparam int unsigned ISS_W = $clog2(BEATS + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   l2mb_state_t           state_q,     state_d;
   logic                  armed_q,     armed_d;
   logic                  err_q,       err_d;
   logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
   l2mb_wbeat_t           wbeat_q,     wbeat_d;
   logic [ISS_W-1:0]      issue_cnt_q, issue_cnt_d;
   logic [TMO_W-1:0]      tmo_cnt_q,   tmo_cnt_d;
   logic                  bus_req_q,   bus_req_d;
   logic                  bus_we_q,    bus_we_d;
   logic [ADDR_WIDTH-1:0] bus_addr_q,  bus_addr_d;
   logic [BEAT_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
   logic [BEAT_BYTES-1:0] bus_wstrb_q, bus_wstrb_d;
   logic                  rdone_q,     rdone_d;
   logic                  wdone_q,     wdone_d;

   logic asm_clr_c;
   logic asm_wr_c;
   logic asm_last_c;

   l2_beat_assembler #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_asm (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clr    (asm_clr_c),
      .i_wr     (asm_wr_c),
      .i_beat   (i_bus_rdata),
      .o_line   (o_rdata),
      .o_last_c (asm_last_c)
   );

   // Next-state, latches and counters.
   always_comb begin
      state_d     = state_q;
      armed_d     = armed_q;
      err_d       = err_q;
      addr_d      = addr_q;
      wbeat_d     = wbeat_q;
      issue_cnt_d = issue_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      asm_clr_c   = 1'b0;
      asm_wr_c    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!i_rreq && !i_wvalid) begin
               armed_d = 1'b1;
            end
            if (armed_q && i_wvalid) begin
               state_d     = WR_ISSUE;
               addr_d      = i_waddr;
               wbeat_d     = '{wdata: i_wdata, wstrb: i_wstrb};
               issue_cnt_d = '0;
               tmo_cnt_d   = '0;
            end else if (armed_q && i_rreq) begin
               state_d     = RD_ISSUE;
               addr_d      = i_addr;
               asm_clr_c   = 1'b1;
               issue_cnt_d = '0;
               tmo_cnt_d   = '0;
            end
         end

         RD_ISSUE, RD_WAIT: begin
            if (state_q == RD_ISSUE && i_bus_gnt) begin
               issue_cnt_d = issue_cnt_q + ISS_W'(1);
               if (issue_cnt_q == ISS_W'(BEATS - 1)) begin
                  state_d = RD_WAIT;
               end
            end
            // Responses may overlap issue; timeout abandons missing beats as zero.
            if (i_bus_rvalid) begin
               asm_wr_c  = 1'b1;
               tmo_cnt_d = '0;
               if (asm_last_c) begin
                  state_d = RD_DONE;
               end
            end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = RD_DONE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end

         WR_ISSUE: begin
            if (i_bus_gnt) begin
               state_d = WR_DONE;
            end
         end

         RD_DONE, WR_DONE: begin
            state_d = IDLE;
            armed_d = 1'b0;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered bus and completion outputs, decoded from the next state.
   always_comb begin
      bus_req_d   = (state_d == RD_ISSUE) || (state_d == WR_ISSUE);
      bus_we_d    = (state_d == WR_ISSUE);
      bus_addr_d  = '0;
      bus_wdata_d = '0;
      bus_wstrb_d = '0;
      rdone_d     = (state_d == RD_DONE);
      wdone_d     = (state_d == WR_DONE);
      if (state_d == RD_ISSUE) begin
         bus_addr_d = addr_d + (ADDR_WIDTH'(issue_cnt_d) << BEAT_SHIFT);
      end else if (state_d == WR_ISSUE) begin
         bus_addr_d  = addr_d;
         bus_wdata_d = wbeat_d.wdata;
         bus_wstrb_d = wbeat_d.wstrb;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         armed_q     <= 1'b1;
         err_q       <= 1'b0;
         addr_q      <= '0;
         wbeat_q     <= '0;
         issue_cnt_q <= '0;
         tmo_cnt_q   <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_wstrb_q <= '0;
         rdone_q     <= 1'b0;
         wdone_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         armed_q     <= armed_d;
         err_q       <= err_d;
         addr_q      <= addr_d;
         wbeat_q     <= wbeat_d;
         issue_cnt_q <= issue_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_wstrb_q <= bus_wstrb_d;
         rdone_q     <= rdone_d;
         wdone_q     <= wdone_d;
      end
   end

   assign o_rdone     = rdone_q;
   assign o_wdone     = wdone_q;
   assign o_err       = err_q;
   assign o_bus_req   = bus_req_q;
   assign o_bus_we    = bus_we_q;
   assign o_bus_addr  = bus_addr_q;
   assign o_bus_wdata = bus_wdata_q;
   assign o_bus_wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_l2_mem_bridge.sv
// Directed scoreboard bench for l2_mem_bridge with a behavioural memory bus model.
module tb_l2_mem_bridge;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [63:0] data;
      logic [7:0]  strb;
   } cmd_t;

   typedef struct {
      logic [63:0] data;
      int          dly;
   } rsp_t;

   logic         i_clk, i_rst_n;
   logic         i_rreq, i_wvalid;
   logic [31:0]  i_addr, i_waddr;
   logic [63:0]  i_wdata;
   logic [7:0]   i_wstrb;
   logic [255:0] o_rdata;
   logic         o_rdone, o_wdone, o_err;
   logic         o_bus_req, o_bus_we;
   logic [31:0]  o_bus_addr;
   logic [63:0]  o_bus_wdata;
   logic [7:0]   o_bus_wstrb;
   logic         i_bus_gnt, i_bus_rvalid;
   logic [63:0]  i_bus_rdata;

   int checks   = 0;
   int failures = 0;

   cmd_t         exp_cmd[$];
   logic [255:0] exp_rd[$];
   int           exp_wr = 0;
   rsp_t         pend[$];

   logic [31:0] salt       = '0;
   int          stall_n    = 0;
   int          dmin       = 0;
   int          dmax       = 0;
   int          rsp_budget = 1000;
   int          rsp_sent   = 0;

   l2_mem_bridge #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (256),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_rreq       (i_rreq),
      .i_addr       (i_addr),
      .i_wvalid     (i_wvalid),
      .i_waddr      (i_waddr),
      .i_wdata      (i_wdata),
      .i_wstrb      (i_wstrb),
      .o_rdata      (o_rdata),
      .o_rdone      (o_rdone),
      .o_wdone      (o_wdone),
      .o_err        (o_err),
      .o_bus_req    (o_bus_req),
      .o_bus_we     (o_bus_we),
      .o_bus_addr   (o_bus_addr),
      .o_bus_wdata  (o_bus_wdata),
      .o_bus_wstrb  (o_bus_wstrb),
      .i_bus_gnt    (i_bus_gnt),
      .i_bus_rvalid (i_bus_rvalid),
      .i_bus_rdata  (i_bus_rdata)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory contents: beat k of a line is 0x11..*(k+1), scrambled by a per-read salt.
   function automatic logic [63:0] beat_data(input logic [31:0] a, input logic [31:0] s);
      logic [63:0] idx;
      idx = 64'((a >> 3) & 32'h3) + 64'd1;
      return (64'h1111_1111_1111_1111 * idx) ^ {s, s};
   endfunction

   // Bus model: grant after stall_n waiting cycles, in-order responses with delay.
   initial begin
      int   stall_cnt;
      rsp_t r;
      stall_cnt    = 0;
      i_bus_gnt    = 1'b0;
      i_bus_rvalid = 1'b0;
      i_bus_rdata  = '0;
      forever begin
         @(posedge i_clk);
         #1;
         if (o_bus_req) begin
            if (stall_cnt >= stall_n) begin
               i_bus_gnt = 1'b1;
               stall_cnt = 0;
            end else begin
               i_bus_gnt = 1'b0;
               stall_cnt++;
            end
         end else begin
            i_bus_gnt = 1'b0;
            stall_cnt = 0;
         end
         i_bus_rvalid = 1'b0;
         i_bus_rdata  = '0;
         if (pend.size() != 0) begin
            if (pend[0].dly > 0) begin
               pend[0].dly--;
            end else begin
               r = pend.pop_front();
               if (rsp_budget > 0) begin
                  i_bus_rvalid = 1'b1;
                  i_bus_rdata  = r.data;
                  rsp_budget--;
                  rsp_sent++;
               end
            end
         end
      end
   end

   // Monitor: command scoreboard, read-line and write-completion checks.
   initial begin
      cmd_t ec, oc;
      forever begin
         @(negedge i_clk);
         if (i_rst_n) begin
            if (o_bus_req && i_bus_gnt) begin
               chk("cmd_expected", 256'(exp_cmd.size() != 0), 256'(1));
               if (exp_cmd.size() != 0) begin
                  ec = exp_cmd.pop_front();
                  oc = '{addr: o_bus_addr, we: o_bus_we, data: o_bus_wdata, strb: o_bus_wstrb};
                  if (!ec.we) begin
                     oc.data = '0;
                     oc.strb = '0;
                  end
                  chk("bus_cmd", 256'(oc), 256'(ec));
               end
               if (!o_bus_we) begin
                  pend.push_back('{data: beat_data(o_bus_addr, salt),
                                   dly: int'($urandom_range(dmax, dmin))});
               end
            end
            if (o_rdone) begin
               chk("rdone_expected", 256'(exp_rd.size() != 0), 256'(1));
               if (exp_rd.size() != 0) chk("rdata", o_rdata, exp_rd.pop_front());
            end
            if (o_wdone) begin
               chk("wdone_expected", 256'(exp_wr > 0), 256'(1));
               if (exp_wr > 0) exp_wr--;
            end
         end
      end
   end

   task automatic start_read(input logic [31:0] a, input logic [31:0] s, input int nb);
      logic [255:0] line;
      repeat (2) @(negedge i_clk);
      salt = s;
      line = '0;
      for (int k = 0; k < 4; k++) begin
         exp_cmd.push_back('{addr: a + 32'(8 * k), we: 1'b0, data: 64'h0, strb: 8'h0});
         if (k < nb) line[64*k +: 64] = beat_data(a + 32'(8 * k), s);
      end
      exp_rd.push_back(line);
      i_addr = a;
      i_rreq = 1'b1;
   endtask

   task automatic start_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] st);
      repeat (2) @(negedge i_clk);
      exp_cmd.push_back('{addr: a, we: 1'b1, data: d, strb: st});
      exp_wr++;
      i_waddr  = a;
      i_wdata  = d;
      i_wstrb  = st;
      i_wvalid = 1'b1;
   endtask

   task automatic wait_pulse(input bit rd, output int lat);
      lat = 0;
      for (int c = 1; c <= 300; c++) begin
         @(negedge i_clk);
         if ((rd && o_rdone) || (!rd && o_wdone)) begin
            lat = c;
            break;
         end
      end
      chk(rd ? "rdone_seen" : "wdone_seen", 256'(lat != 0), 256'(1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=stuck expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int base;
      logic [255:0] part;

      i_rst_n  = 1'b0;
      i_rreq   = 1'b0;
      i_wvalid = 1'b0;
      i_addr   = '0;
      i_waddr  = '0;
      i_wdata  = '0;
      i_wstrb  = '0;
      repeat (3) @(negedge i_clk);
      chk("reset_ctrl", 256'({o_rdone, o_wdone, o_err, o_bus_req, o_bus_we}), 256'(0));
      chk("reset_bus", 256'({o_bus_addr, o_bus_wdata, o_bus_wstrb}), 256'(0));
      chk("reset_rdata", o_rdata, 256'(0));
      i_rst_n = 1'b1;

      // Basic read, gnt always, response one cycle after grant.
      start_read(32'h0000_1000, 32'h0, 4);
      wait_pulse(1'b1, lat);
      i_rreq = 1'b0;
      chk("rd_latency", 256'(lat), 256'(6));
      chk("rd_line_literal", o_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

      // Stalled grants and random response delays.
      stall_n = 3;
      dmin    = 0;
      dmax    = 4;
      start_read(32'h0000_3040, 32'hA5A5_0001, 4);
      wait_pulse(1'b1, lat);
      i_rreq = 1'b0;
      repeat (4) @(negedge i_clk);
      chk("stall_cmd_count", 256'(exp_cmd.size()), 256'(0));
      chk("stall_rd_count", 256'(exp_rd.size()), 256'(0));
      stall_n = 0;
      dmax    = 0;

      // Posted write.
      start_write(32'h0000_2000, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F);
      wait_pulse(1'b0, lat);
      i_wvalid = 1'b0;
      chk("wr_latency", 256'(lat), 256'(2));

      // Simultaneous read and write: write wins, read waits for re-arm.
      start_write(32'h0000_2100, 64'h0123_4567_89AB_CDEF, 8'hF0);
      i_addr = 32'h0000_6000;
      i_rreq = 1'b1;
      wait_pulse(1'b0, lat);
      i_wvalid = 1'b0;
      chk("prio_wr_latency", 256'(lat), 256'(2));
      repeat (6) @(negedge i_clk);
      chk("prio_no_reissue", 256'({o_bus_req, o_rdone}), 256'(0));
      chk("prio_cmd_count", 256'(exp_cmd.size()), 256'(0));
      i_rreq = 1'b0;
      start_read(32'h0000_6000, 32'h5A5A_0002, 4);
      wait_pulse(1'b1, lat);
      i_rreq = 1'b0;
      chk("prio_rd_latency", 256'(lat), 256'(6));

      // Timeout: only two responses ever arrive.
      chk("err_before_tmo", 256'(o_err), 256'(0));
      rsp_budget = 2;
      start_read(32'h0000_7000, 32'h0F0F_0003, 2);
      wait_pulse(1'b1, lat);
      i_rreq = 1'b0;
      chk("tmo_latency", 256'(lat), 256'(20));
      chk("tmo_err", 256'(o_err), 256'(1));
      chk("tmo_upper_zero", 256'(o_rdata[255:128]), 256'(0));
      rsp_budget = 1000;
      start_read(32'h0000_7020, 32'h3C3C_0004, 4);
      wait_pulse(1'b1, lat);
      i_rreq = 1'b0;
      chk("err_sticky", 256'(o_err), 256'(1));

      // Reset in RD_WAIT with two beats still outstanding.
      dmin = 6;
      dmax = 6;
      base = rsp_sent;
      start_read(32'h0000_5000, 32'h0BAD_F00D, 4);
      for (int c = 0; c < 200; c++) begin
         @(negedge i_clk);
         if (rsp_sent >= base + 2) break;
      end
      @(negedge i_clk);
      part = '0;
      part[63:0]   = beat_data(32'h0000_5000, 32'h0BAD_F00D);
      part[127:64] = beat_data(32'h0000_5008, 32'h0BAD_F00D);
      chk("partial_line", o_rdata, part);
      #2;
      i_rst_n = 1'b0;
      i_rreq  = 1'b0;
      #1;
      chk("async_rst_ctrl", 256'({o_rdone, o_wdone, o_err, o_bus_req, o_bus_we}), 256'(0));
      chk("async_rst_bus", 256'({o_bus_addr, o_bus_wdata, o_bus_wstrb}), 256'(0));
      chk("async_rst_rdata", o_rdata, 256'(0));
      exp_rd.delete();
      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge i_clk);
         if (pend.size() == 0 && rsp_sent >= base + 4) break;
      end
      repeat (2) @(negedge i_clk);
      chk("late_rsp_sent", 256'(rsp_sent - base), 256'(4));
      chk("late_rsp_ignored", o_rdata, 256'(0));
      chk("rst_cmd_count", 256'(exp_cmd.size()), 256'(0));
      dmin = 0;
      dmax = 0;
      start_read(32'h0000_8000, 32'h7777_0005, 4);
      wait_pulse(1'b1, lat);
      i_rreq = 1'b0;
      chk("post_rst_latency", 256'(lat), 256'(6));
      repeat (4) @(negedge i_clk);
      chk("final_cmd_count", 256'(exp_cmd.size()), 256'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/l2_mem_bridge.md
# l2_mem_bridge

Downstream neighbour of the shared L2 cache: converts its line-level memory port (256-bit read fill, 64-bit strobed write) into a 64-bit beat-oriented command/response bus toward main memory. Reads are split into DATA_WIDTH/64 beat commands with up to BEATS outstanding; in-order responses are assembled into a full line. Writes are forwarded as a single posted beat. A response timeout flags a hung memory without deadlocking the L2.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 256, line width; BEATS = DATA_WIDTH/64
- TIMEOUT_CYCLES, 1024, max idle cycles between read responses before error
- i_clk  in  1  clock
- i_rst_n  in  1  reset: asynchronous, active-low
- i_rreq  in  1  L2 read request, level, held until o_rdone
- i_addr  in  ADDR_WIDTH  read line address (offset bits zero)
- i_wvalid  in  1  L2 write request, level, held until o_wdone
- i_waddr  in  ADDR_WIDTH  write address
- i_wdata  in  64  write beat
- i_wstrb  in  8  write byte strobes
- o_rdata  out  DATA_WIDTH  assembled line, valid while o_rdone
- o_rdone  out  1  one-cycle read completion pulse
- o_wdone  out  1  one-cycle write completion pulse
- o_err  out  1  sticky timeout flag
- o_bus_req  out  1  command valid
- o_bus_we  out  1  command is write
- o_bus_addr  out  ADDR_WIDTH  beat address
- o_bus_wdata  out  64  write data
- o_bus_wstrb  out  8  write strobes
- i_bus_gnt  in  1  command accepted this cycle (req && gnt = handshake)
- i_bus_rvalid  in  1  read response beat valid
- i_bus_rdata  in  64  read response data

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RD_DONE, WR_DONE.
- IDLE: accepts only when armed; i_wvalid has priority over i_rreq if both high -> WR_ISSUE, else i_rreq -> RD_ISSUE. Latch address/data/strobes; clear line register, issue counter, response counter, timeout counter.
- RD_ISSUE: o_bus_req=1, o_bus_we=0, o_bus_addr = line_addr + 8*issue_cnt; issue_cnt increments on gnt; after BEATS grants -> RD_WAIT. Responses are collected concurrently.
- Response beat k (k = rsp_cnt) written to o_rdata[64k+:64]; rsp_cnt increments on rvalid. Last response (rsp_cnt==BEATS-1) -> RD_DONE, from either RD_ISSUE or RD_WAIT. rvalid in IDLE/WR states is ignored.
- Timeout: counter counts cycles in RD_ISSUE/RD_WAIT without rvalid, reset on each rvalid; reaching TIMEOUT_CYCLES sets o_err and forces RD_DONE with missing beats zero. Subsequent stray responses ignored.
- WR_ISSUE: o_bus_req=1, o_bus_we=1, addr/data/strobes from latch; on gnt -> WR_DONE (posted write).
- RD_DONE / WR_DONE: pulse o_rdone / o_wdone one cycle, -> IDLE, clear armed.
- armed: set once i_rreq and i_wvalid are both observed low in IDLE; prevents re-issuing a request still held high in the cycle after done.
- o_err cleared only by reset.

## Timing
- Reset: state IDLE, all outputs 0, o_rdata 0, armed 1, counters 0.
- Commands and outputs are registered-state driven; o_bus_req may stay high back-to-back across beats.
- Minimum read latency with gnt tied high and rvalid one cycle after gnt: request seen cycle 0, commands cycles 1-4, responses 2-5, o_rdone cycle 6.
- Minimum write latency: command cycle 1, o_wdone cycle 2.
- o_rdata holds last assembled line until next read starts.
- Reset mid-burst: returns to IDLE immediately; outstanding responses after reset are ignored.

## Structure
- Package l2_mem_pkg: BEAT_WIDTH=64, BEAT_BYTES=8, state enum l2mb_state_t.
- Sub-module l2_beat_assembler: rsp counter + line register with clear, write-beat, and last-beat outputs.

## Test plan
- Read 0x0000_1000, gnt=1, responses 0x11..,0x22..,0x33..,0x44.. -> bus addrs 0x1000/08/10/18, o_rdone cycle 6, o_rdata = {0x44..,0x33..,0x22..,0x11..}.
- gnt stalls 3 cycles per beat, responses delayed random -> same line, one o_rdone, exactly 4 commands.
- Write 0x2000, data 0xDEADBEEF_CAFEF00D, wstrb 0x0F -> one write command with those values, o_wdone one cycle after gnt.
- i_rreq and i_wvalid both high from IDLE -> write first; read issued only after both seen low then i_rreq re-raised.
- Read with only 2 responses, TIMEOUT_CYCLES=16 -> o_err=1 after 16 idle cycles, o_rdone pulses, upper 128 bits zero.
- Reset asserted during RD_WAIT with 2 beats pending -> all outputs 0 asynchronously, late rvalid ignored, next read correct.
